rr_req_frontend: RTL and testbench

- Per-client request front-end placed directly upstream of the round-robin arbiter.
- Buffers transactions from N clients in small per-client FIFOs and drives the arbiter's req vector from FIFO occupancy.
- Consumes the arbiter's one-hot grant, popping one beat per granted cycle into a single registered output stage toward the shared resource.

---
 rtl/rr_req_frontend.sv | 146 ++++++++++++++
 tb/tb_rr_req_frontend.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_frontend.sv
// Per-client request FIFOs feeding a round-robin arbiter, with one registered output beat.
// Optional per-client beat and idle-grant statistics are enabled by defining RR_FRONTEND_STATS_EN.
module rr_req_frontend #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            in_valid,
    output logic [N-1:0]            in_ready,
    input  logic [N*DATA_W-1:0]     in_data,
    output logic [N-1:0]            req,
    input  logic [N-1:0]            grant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [$clog2(N)-1:0]    out_client,
    output logic                    grant_err
`ifdef RR_FRONTEND_STATS_EN
    ,
    output logic [N*16-1:0]         beat_cnt,
    output logic [N*16-1:0]         idle_grant_cnt
`endif
);

    localparam int CW    = $clog2(N);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem    [N][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [N];
    logic [PTR_W-1:0]  rd_ptr [N];
    logic [CNT_W-1:0]  count  [N];

    logic [N-1:0]      push;
    logic [N-1:0]      pop;
    logic              multi_hot;
    logic              out_can_load;
    logic              pop_any;
    logic [CW-1:0]     pop_idx;

    // A multi-hot grant blocks every pop so a misbehaving arbiter cannot drain two queues at once.
    assign multi_hot    = |(grant & (grant - N'(1)));
    assign out_can_load = !out_valid || out_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        in_ready = '0;
        req      = '0;
        push     = '0;
        pop      = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = (count[k] < CNT_W'(DEPTH));
            req[k]      = (count[k] != '0);
            push[k]     = in_valid[k] && in_ready[k];
            pop[k]      = grant[k] && req[k] && out_can_load && !multi_hot;
        end
    end

    always_comb begin
        pop_any = 1'b0;
        pop_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (pop[k]) begin
                pop_any = 1'b1;
                pop_idx = CW'(k);
            end
        end
    end

    // NOTE: FIFO storage is not reset; pointers and counts alone define which entries are live.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_client <= '0;
            grant_err  <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                end
                case ({push[k], pop[k]})
                    2'b10:   count[k] <= count[k] + CNT_W'(1);
                    2'b01:   count[k] <= count[k] - CNT_W'(1);
                    default: count[k] <= count[k];
                endcase
            end

            if (multi_hot) begin
                grant_err <= 1'b1;
            end

            if (pop_any) begin
                out_valid  <= 1'b1;
                out_data   <= mem[pop_idx][rd_ptr[pop_idx]];
                out_client <= pop_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RR_FRONTEND_STATS_EN
    logic grant_one_hot;

    assign grant_one_hot = (grant != '0) && !multi_hot;

    // Saturating per-client counters; an idle grant is a valid one-hot grant to an empty queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt       <= '0;
            idle_grant_cnt <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (pop[k] && beat_cnt[k*16 +: 16] != 16'hFFFF) begin
                    beat_cnt[k*16 +: 16] <= beat_cnt[k*16 +: 16] + 16'd1;
                end
                if (grant[k] && !req[k] && grant_one_hot
                    && idle_grant_cnt[k*16 +: 16] != 16'hFFFF) begin
                    idle_grant_cnt[k*16 +: 16] <= idle_grant_cnt[k*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_req_frontend.sv
// Directed bench for rr_req_frontend: reset, draining, full FIFO wrap, backpressure,
// simultaneous push/pop, push-while-granted, idle grant and multi-hot grant.
module tb_rr_req_frontend;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [N*DATA_W-1:0]  in_data;
    logic [N-1:0]         req;
    logic [N-1:0]         grant;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic [1:0]           out_client;
    logic                 grant_err;

    int errors = 0;
    int checks = 0;

    rr_req_frontend #(.N(N), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .req        (req),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_client (out_client),
        .grant_err  (grant_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [DATA_W-1:0] v);
        in_data[k*DATA_W +: DATA_W] = v;
    endtask

    task automatic check_beat(input string tag, input logic [7:0] exp_data, input logic [1:0] exp_client);
        check({tag, " valid"},  32'(out_valid),  1);
        check({tag, " data"},   32'(out_data),   32'(exp_data));
        check({tag, " client"}, 32'(out_client), 32'(exp_client));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        grant     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("por req",       32'(req),        0);
        check("por in_ready",  32'(in_ready),   'b1111);
        check("por out_valid", 32'(out_valid),  0);
        check("por out_data",  32'(out_data),   0);
        check("por out_client",32'(out_client), 0);
        check("por grant_err", 32'(grant_err),  0);

        // Two entries in every client, then reset discards them.
        in_valid = 'b1111;
        for (int k = 0; k < N; k++) set_data(k, 8'(8'hE0 + k));
        tick();
        tick();
        in_valid = '0;
        check("preload req", 32'(req), 'b1111);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst req",       32'(req),       0);
        check("rst in_ready",  32'(in_ready),  'b1111);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst grant_err", 32'(grant_err), 0);

        // Client 2 drains two beats in order.
        in_valid = 'b0100;
        set_data(2, 8'hA1);
        tick();
        set_data(2, 8'hA2);
        tick();
        in_valid = '0;
        check("c2 req", 32'(req), 'b0100);
        grant     = 'b0100;
        out_ready = 1'b1;
        tick();
        check_beat("c2 beat0", 8'hA1, 2'd2);
        tick();
        check_beat("c2 beat1", 8'hA2, 2'd2);
        check("c2 req drained", 32'(req), 0);
        tick();
        check("c2 idle out_valid", 32'(out_valid), 0);
        grant = '0;

        // Client 1 filled to DEPTH; fifth push is dropped; drain proves pointer wrap.
        in_valid = 'b0010;
        for (int i = 0; i < DEPTH; i++) begin
            set_data(1, 8'(8'h10 + i));
            tick();
        end
        check("c1 full in_ready", 32'(in_ready), 'b1101);
        set_data(1, 8'h99);
        tick();
        in_valid = '0;
        check("c1 still full", 32'(in_ready), 'b1101);
        grant = 'b0010;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check_beat($sformatf("c1 beat%0d", i), 8'(8'h10 + i), 2'd1);
        end
        grant = '0;
        tick();
        check("c1 drained out_valid", 32'(out_valid), 0);
        check("c1 fifth push dropped", 32'(req), 0);

        // Backpressure on client 0.
        in_valid = 'b0001;
        set_data(0, 8'h55);
        tick();
        set_data(0, 8'h66);
        tick();
        in_valid  = '0;
        grant     = 'b0001;
        out_ready = 1'b0;
        tick();
        check_beat("bp first", 8'h55, 2'd0);
        tick();
        tick();
        check_beat("bp held", 8'h55, 2'd0);
        check("bp req held", 32'(req), 'b0001);
        out_ready = 1'b1;
        tick();
        check_beat("bp release", 8'h66, 2'd0);
        grant = '0;
        tick();
        check("bp done out_valid", 32'(out_valid), 0);
        check("bp done req", 32'(req), 0);

        // Client 3 at count 2 with a push and a pop every cycle.
        in_valid = 'b1000;
        set_data(3, 8'h30);
        tick();
        set_data(3, 8'h31);
        tick();
        grant = 'b1000;
        for (int i = 0; i < 4; i++) begin
            set_data(3, 8'(8'h32 + i));
            tick();
            check_beat($sformatf("pp beat%0d", i), 8'(8'h30 + i), 2'd3);
            check($sformatf("pp req%0d", i), 32'(req), 'b1000);
            check($sformatf("pp in_ready%0d", i), 32'(in_ready), 'b1111);
        end
        in_valid = '0;
        tick();
        check_beat("pp tail0", 8'h34, 2'd3);
        tick();
        check_beat("pp tail1", 8'h35, 2'd3);
        tick();
        check("pp end out_valid", 32'(out_valid), 0);
        check("pp end req", 32'(req), 0);
        grant = '0;

        // Push into an empty FIFO while it is granted: pop only on the following cycle.
        grant    = 'b0100;
        in_valid = 'b0100;
        set_data(2, 8'hB0);
        tick();
        in_valid = '0;
        check("pwg no pop", 32'(out_valid), 0);
        check("pwg req", 32'(req), 'b0100);
        tick();
        check_beat("pwg beat", 8'hB0, 2'd2);
        tick();
        check("pwg idle grant out_valid", 32'(out_valid), 0);
        check("pwg idle grant no err", 32'(grant_err), 0);
        grant = '0;

        // Multi-hot grant: no pop, sticky error, queued data intact.
        in_valid = 'b0011;
        set_data(0, 8'h70);
        set_data(1, 8'h71);
        tick();
        in_valid = '0;
        grant = 'b0011;
        tick();
        check("mh out_valid", 32'(out_valid), 0);
        check("mh grant_err", 32'(grant_err), 1);
        check("mh req", 32'(req), 'b0011);
        grant = '0;
        tick();
        check("mh sticky", 32'(grant_err), 1);
        grant = 'b0001;
        tick();
        check_beat("mh c0", 8'h70, 2'd0);
        grant = 'b0010;
        tick();
        check_beat("mh c1", 8'h71, 2'd1);
        grant = '0;
        tick();
        check("mh drained req", 32'(req), 0);
        check("mh sticky2", 32'(grant_err), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mh cleared", 32'(grant_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
